// File: rtl/fifo_write_packer.sv
// fifo_write_packer
//   Packs a little-endian byte stream (valid/ready/last) into DATA_WIDTH words and writes
//   each complete or end-of-packet word into a downstream FIFO, stalling on fifo_full_i.
//
//   Optional feature macro: FWP_LEN_TRAILER_EN
//     When defined, every packet is followed by one extra word holding the zero-extended,
//     saturating byte count of that packet.
//
// Ports
//   clock_i               sole clock
//   reset_i               asynchronous, active-high reset
//   s_tdata_i             input byte
//   s_tvalid_i            byte valid
//   s_tready_o            byte accepted when s_tvalid_i & s_tready_o
//   s_tlast_i             byte is last of packet
//   fifo_clock_o          pass-through of clock_i
//   fifo_reset_o          pass-through of reset_i
//   fifo_wr_data_o        word to write
//   fifo_wr_en_o          write strobe, never high while fifo_full_i
//   fifo_full_i           FIFO full
//   fifo_almost_full_i    reserved, unused
//   fifo_wr_data_count_i  reserved, unused
module fifo_write_packer #(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned DATA_COUNT_WIDTH = 1,
   parameter int unsigned LEN_WIDTH        = 16
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic [7:0]                  s_tdata_i,
   input  logic                        s_tvalid_i,
   output logic                        s_tready_o,
   input  logic                        s_tlast_i,
   output logic                        fifo_clock_o,
   output logic                        fifo_reset_o,
   output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
   output logic                        fifo_wr_en_o,
   input  logic                        fifo_full_i,
   input  logic                        fifo_almost_full_i,
   input  logic [DATA_COUNT_WIDTH-1:0] fifo_wr_data_count_i
);

   localparam int unsigned NumLanes = DATA_WIDTH / 8;
   localparam int unsigned LaneW    = $clog2(NumLanes);

   typedef enum logic [1:0] {
      StFill    = 2'd0,
      StWrite   = 2'd1
`ifdef FWP_LEN_TRAILER_EN
      ,
      StTrailer = 2'd2
`endif
   } state_e;

   state_e                  state_q;
   logic [LaneW-1:0]        lane_q;
   logic [DATA_WIDTH-1:0]   word_q;
   logic                    last_q;
   logic                    ready_q;
`ifdef FWP_LEN_TRAILER_EN
   logic [LEN_WIDTH-1:0]    len_q;
`endif

   logic accept;
   logic unused_inputs;

   assign accept         = s_tvalid_i & ready_q;
   assign s_tready_o     = ready_q;
   assign fifo_wr_data_o = word_q;
   // Any non-FILL state has a word waiting; the strobe follows full combinationally.
   assign fifo_wr_en_o   = (state_q != StFill) & ~fifo_full_i;
   assign fifo_clock_o   = clock_i;
   assign fifo_reset_o   = reset_i;
   assign unused_inputs  = fifo_almost_full_i ^ (^fifo_wr_data_count_i);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StFill;
         lane_q  <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
`ifdef FWP_LEN_TRAILER_EN
         len_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            StFill: begin
               // ready is low for the first clock after reset, then high throughout FILL
               ready_q <= 1'b1;
               if (accept) begin
                  word_q[8*lane_q +: 8] <= s_tdata_i;
`ifdef FWP_LEN_TRAILER_EN
                  if (len_q != {LEN_WIDTH{1'b1}}) begin
                     len_q <= len_q + 1'b1;
                  end
`endif
                  if ((lane_q == LaneW'(NumLanes - 1)) || s_tlast_i) begin
                     lane_q  <= '0;
                     last_q  <= s_tlast_i;
                     ready_q <= 1'b0;
                     state_q <= StWrite;
                  end else begin
                     lane_q <= lane_q + 1'b1;
                  end
               end
            end
            StWrite: begin
               if (!fifo_full_i) begin
                  last_q <= 1'b0;
`ifdef FWP_LEN_TRAILER_EN
                  if (last_q) begin
                     // Reuse the word register to present the length trailer.
                     word_q  <= DATA_WIDTH'(len_q);
                     state_q <= StTrailer;
                  end else begin
                     word_q  <= '0;
                     ready_q <= 1'b1;
                     state_q <= StFill;
                  end
`else
                  word_q  <= '0;
                  ready_q <= 1'b1;
                  state_q <= StFill;
`endif
               end
            end
`ifdef FWP_LEN_TRAILER_EN
            StTrailer: begin
               if (!fifo_full_i) begin
                  word_q  <= '0;
                  len_q   <= '0;
                  ready_q <= 1'b1;
                  state_q <= StFill;
               end
            end
`endif
            default: begin
               state_q <= StFill;
            end
         endcase
      end
   end

endmodule
